// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// optional parity, one or two stop bits and a valid/ack output handshake with overrun.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_PRE     = SC_W'(M - 1);
  localparam logic [SC_W-1:0]  SC_MID     = SC_W'(M);
  localparam logic [SC_W-1:0]  SC_DEC     = SC_W'(M + 1);
  localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST    = BC_W'(DATA_BITS - 1);
  localparam logic             PAR_TARGET = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 syncMeta_q;
  logic                 rxdSync_q;
  logic [DIV_W-1:0]     tickCnt_q;
  logic [DIV_W-1:0]     tickCnt_d;
  logic                 tick;
  state_t               state_q;
  logic [SC_W-1:0]      sc_q;
  logic [BC_W-1:0]      bitCnt_q;
  logic                 stopCnt_q;
  logic                 sampA_q;
  logic                 sampB_q;
  logic                 bitDec;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parErrPend_q;
  logic                 frameErrPend_q;
  logic [DATA_BITS-1:0] dataOut_q;
  logic                 dataValid_q;
  logic                 parityErr_q;
  logic                 frameErr_q;
  logic                 overrun_q;
  logic                 busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta_q <= 1'b1;
      rxdSync_q  <= 1'b1;
    end else begin
      syncMeta_q <= rxd;
      rxdSync_q  <= syncMeta_q;
    end
  end

  assign tick = enable && (tickCnt_q == DIV_LAST);

  always_comb begin
    tickCnt_d = tickCnt_q;
    if (enable) tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tickCnt_q <= '0;
    else       tickCnt_q <= tickCnt_d;
  end

  // The third vote is the live synchronised sample taken on the decision tick.
  assign bitDec = (sampA_q & sampB_q) | (sampA_q & rxdSync_q) | (sampB_q & rxdSync_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sc_q           <= '0;
      bitCnt_q       <= '0;
      stopCnt_q      <= 1'b0;
      sampA_q        <= 1'b1;
      sampB_q        <= 1'b1;
      shift_q        <= '0;
      parErrPend_q   <= 1'b0;
      frameErrPend_q <= 1'b0;
      dataOut_q      <= '0;
      dataValid_q    <= 1'b0;
      parityErr_q    <= 1'b0;
      frameErr_q     <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      if (dataValid_q && data_ack) begin
        dataValid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (tick) begin
        if (state_q != S_IDLE) begin
          sc_q <= (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
          if (sc_q == SC_PRE) sampA_q <= rxdSync_q;
          if (sc_q == SC_MID) sampB_q <= rxdSync_q;
        end
        case (state_q)
          S_IDLE: begin
            if (!rxdSync_q) begin
              state_q        <= S_START;
              sc_q           <= '0;
              busy_q         <= 1'b1;
              parErrPend_q   <= 1'b0;
              frameErrPend_q <= 1'b0;
              stopCnt_q      <= 1'b0;
            end
          end
          S_START: begin
            if (sc_q == SC_DEC && bitDec) begin
              state_q <= S_IDLE;
              sc_q    <= '0;
              busy_q  <= 1'b0;
            end else if (sc_q == SC_LAST) begin
              state_q  <= S_DATA;
              bitCnt_q <= '0;
            end
          end
          S_DATA: begin
            if (sc_q == SC_DEC) shift_q <= {bitDec, shift_q[DATA_BITS-1:1]};
            if (sc_q == SC_LAST) begin
              if (bitCnt_q == BC_LAST) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
              else                     bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            if (sc_q == SC_DEC) parErrPend_q <= ((^shift_q) ^ bitDec) != PAR_TARGET;
            if (sc_q == SC_LAST) state_q <= S_STOP;
          end
          S_STOP: begin
            // Leaving half a bit early on the last stop lets back-to-back frames resync.
            if (sc_q == SC_DEC) begin
              if (STOP_BITS == 2 && !stopCnt_q) begin
                if (!bitDec) frameErrPend_q <= 1'b1;
              end else begin
                dataOut_q   <= shift_q;
                parityErr_q <= parErrPend_q;
                frameErr_q  <= frameErrPend_q | ~bitDec;
                dataValid_q <= 1'b1;
                overrun_q   <= dataValid_q & ~data_ack;
                state_q     <= S_IDLE;
                sc_q        <= '0;
                bitCnt_q    <= '0;
                stopCnt_q   <= 1'b0;
                busy_q      <= 1'b0;
              end
            end else if (sc_q == SC_LAST) begin
              stopCnt_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            sc_q    <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receiver configurations on one clock, frames driven bit by bit,
// expected words queued at send time and compared once the receiver commits them.
module tb_uart_rx_param;

  localparam int CF       = 1_600_000;
  localparam int BR       = 100_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 16;

  typedef struct {
    int       idx;
    logic [8:0] data;
    logic     pe;
    logic     fe;
    bit       ackAtCommit;
  } expT;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rxdLine [4];
  logic       ackLine [4];
  wire  [7:0] dOut0, dOut1, dOut2;
  wire  [4:0] dOut3;
  wire  [3:0] dValid, pErr, fErr, ovr, busyO;

  int  dataBitsCfg [4] = '{8, 8, 8, 5};
  int  parityCfg   [4] = '{0, 2, 0, 1};
  int  stopCfg     [4] = '{1, 1, 2, 1};
  bit  modelValid  [4];
  expT sbQ [$];
  int  nCompared   = 0;
  int  nMismatched = 0;
  int  latCnt;
  bit  latOk;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxdLine[0]), .data_out(dOut0), .data_valid(dValid[0]),
    .data_ack(ackLine[0]), .parity_err(pErr[0]), .frame_err(fErr[0]), .overrun(ovr[0]), .busy(busyO[0]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) uEven (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxdLine[1]), .data_out(dOut1), .data_valid(dValid[1]),
    .data_ack(ackLine[1]), .parity_err(pErr[1]), .frame_err(fErr[1]), .overrun(ovr[1]), .busy(busyO[1]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) uStop2 (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxdLine[2]), .data_out(dOut2), .data_valid(dValid[2]),
    .data_ack(ackLine[2]), .parity_err(pErr[2]), .frame_err(fErr[2]), .overrun(ovr[2]), .busy(busyO[2]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) uOdd5 (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxdLine[3]), .data_out(dOut3), .data_valid(dValid[3]),
    .data_ack(ackLine[3]), .parity_err(pErr[3]), .frame_err(fErr[3]), .overrun(ovr[3]), .busy(busyO[3]));

  // Packs one receiver's outputs as {busy, overrun, frame_err, parity_err, data_valid, data[8:0]}.
  function automatic logic [13:0] stat(input int idx);
    logic [8:0] d;
    case (idx)
      0:       d = {1'b0, dOut0};
      1:       d = {1'b0, dOut1};
      2:       d = {1'b0, dOut2};
      default: d = {4'b0, dOut3};
    endcase
    return {busyO[idx], ovr[idx], fErr[idx], pErr[idx], dValid[idx], d};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame onto a receiver's line; optional corruptions, a one-clock glitch at the
  // middle sample of a data bit, an ack pulse on the commit cycle and an enable pause.
  task automatic applyStimulus(input int idx, input logic [8:0] data, input bit badParity, input bit stopLow,
                               input int glitchBit, input bit ackAtCommit, input int pauseBit, input bit doPush);
    logic [8:0] mask;
    logic [8:0] d;
    logic       p;
    logic       v;
    logic       lineBits [$];
    expT        e;
    mask = (9'd1 << dataBitsCfg[idx]) - 9'd1;
    d    = data & mask;
    lineBits = {};
    lineBits.push_back(1'b0);
    for (int i = 0; i < dataBitsCfg[idx]; i++) lineBits.push_back(d[i]);
    if (parityCfg[idx] != 0) begin
      p = (^d) ^ (parityCfg[idx] == 1);
      if (badParity) p = ~p;
      lineBits.push_back(p);
    end
    for (int s = 0; s < stopCfg[idx]; s++) lineBits.push_back((stopLow && s == stopCfg[idx] - 1) ? 1'b0 : 1'b1);
    if (doPush) begin
      e.idx = idx;
      e.data = d;
      e.pe = badParity && (parityCfg[idx] != 0);
      e.fe = stopLow;
      e.ackAtCommit = ackAtCommit;
      sbQ.push_back(e);
    end
    for (int b = 0; b < lineBits.size(); b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        v = lineBits[b];
        if (glitchBit >= 0 && b == glitchBit + 1 && c == 9) v = ~v;
        rxdLine[idx] = v;
        if (ackAtCommit && b == lineBits.size() - 1) ackLine[idx] = (c == 12);
        if (b == pauseBit && c == 4) begin
          enable = 1'b0;
          repeat (10) begin
            @(negedge clk);
            rxdLine[idx] = v;
          end
          enable = 1'b1;
        end
      end
    end
    if (stopLow) begin
      repeat (20) begin
        @(negedge clk);
        rxdLine[idx] = 1'b1;
      end
    end
  endtask

  task automatic checkScoreboard(input string tag);
    expT         e;
    logic [13:0] s;
    int          waited;
    logic        expOv;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_pending"}, 16'(sbQ.size()), 16'd1);
      return;
    end
    e = sbQ.pop_front();
    s = stat(e.idx);
    waited = 0;
    while (!s[9] && waited < 300) begin
      @(negedge clk);
      s = stat(e.idx);
      waited++;
    end
    expOv = modelValid[e.idx] && !e.ackAtCommit;
    modelValid[e.idx] = 1'b1;
    checkOutput({tag, "_valid"},   16'(s[9]),   16'd1);
    checkOutput({tag, "_data"},    16'(s[8:0]), 16'(e.data));
    checkOutput({tag, "_parity"},  16'(s[10]),  16'(e.pe));
    checkOutput({tag, "_frame"},   16'(s[11]),  16'(e.fe));
    checkOutput({tag, "_overrun"}, 16'(s[12]),  16'(expOv));
  endtask

  task automatic ackWord(input int idx, input string tag);
    logic [13:0] s;
    @(negedge clk);
    ackLine[idx] = 1'b1;
    @(negedge clk);
    ackLine[idx] = 1'b0;
    modelValid[idx] = 1'b0;
    s = stat(idx);
    checkOutput({tag, "_valid"},   16'(s[9]),  16'd0);
    checkOutput({tag, "_overrun"}, 16'(s[12]), 16'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxdLine[i]    = 1'b1;
      ackLine[i]    = 1'b0;
      modelValid[i] = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_dut%0d", i), 16'(stat(i)), 16'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] 8N1 back-to-back 0x55 / 0xA3 with latency measurement");
    fork
      begin
        applyStimulus(0, 9'h55, 0, 0, -1, 0, -1, 1);
        applyStimulus(0, 9'hA3, 0, 0, -1, 0, -1, 1);
      end
      begin
        @(negedge clk);
        latCnt = 0;
        latOk  = 0;
        for (int i = 0; i < 400; i++) begin
          @(posedge clk);
          #1;
          if (dValid[0]) begin
            latOk = 1;
            break;
          end
          latCnt++;
        end
        checkOutput("latency", latOk ? 16'(latCnt) : 16'hFFFF, 16'd156);
        checkScoreboard("8n1_55");
        ackWord(0, "ack_55");
      end
    join
    checkScoreboard("8n1_A3");
    ackWord(0, "ack_A3");

    $display("[TB] start-bit glitch and mid-bit noise");
    repeat (6) begin
      @(negedge clk);
      rxdLine[0] = 1'b0;
    end
    @(negedge clk);
    rxdLine[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("glitch_busy_high", 16'(busyO[0]), 16'd1);
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_low", 16'(busyO[0]), 16'd0);
    checkOutput("glitch_no_valid", 16'(dValid[0]), 16'd0);
    applyStimulus(0, 9'h00, 0, 0, 3, 0, -1, 1);
    checkScoreboard("noise_00");
    ackWord(0, "ack_00");

    $display("[TB] overrun without ack, then ack on the commit cycle");
    applyStimulus(0, 9'h11, 0, 0, -1, 0, -1, 1);
    checkScoreboard("ovr_11");
    applyStimulus(0, 9'h22, 0, 0, -1, 0, -1, 1);
    checkScoreboard("ovr_22");
    ackWord(0, "ack_22");
    applyStimulus(0, 9'h33, 0, 0, -1, 0, -1, 1);
    checkScoreboard("ovr_33");
    applyStimulus(0, 9'h44, 0, 0, -1, 1, -1, 1);
    checkScoreboard("ackcommit_44");
    ackWord(0, "ack_44");

    $display("[TB] enable pause mid-frame");
    applyStimulus(0, 9'h96, 0, 0, -1, 0, 4, 1);
    checkScoreboard("pause_96");
    ackWord(0, "ack_96");

    $display("[TB] even parity");
    applyStimulus(1, 9'h07, 0, 0, -1, 0, -1, 1);
    checkScoreboard("even_ok");
    ackWord(1, "ack_even_ok");
    applyStimulus(1, 9'h07, 1, 0, -1, 0, -1, 1);
    checkScoreboard("even_bad");
    ackWord(1, "ack_even_bad");

    $display("[TB] two stop bits");
    applyStimulus(2, 9'h3C, 0, 1, -1, 0, -1, 1);
    checkScoreboard("stop2_bad");
    ackWord(2, "ack_stop2_bad");
    applyStimulus(2, 9'h5A, 0, 0, -1, 0, -1, 1);
    checkScoreboard("stop2_ok");
    ackWord(2, "ack_stop2_ok");

    $display("[TB] 5 data bits, odd parity, reset mid-frame");
    applyStimulus(3, 9'h1F, 0, 0, -1, 0, -1, 1);
    checkScoreboard("odd5_1F");
    fork
      applyStimulus(3, 9'h0A, 0, 0, -1, 0, -1, 0);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++) modelValid[i] = 1'b0;
    checkOutput("midreset_dut3", 16'(stat(3)), 16'd0);
    checkOutput("midreset_dut0", 16'(stat(0)), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("postreset_dut3", 16'(stat(3)), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
